// File: rtl/nibble_packer.sv
// Packs masked 4-bit nibbles into 32-bit words (first nibble in the low bits)
// and queues the finished words in a small output FIFO.
module nibble_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [3:0][3:0]             NIBBLE_IN,
    input  logic [3:0]                  MASK_IN,
    input  logic                        VALID_IN,
    input  logic                        FLUSH,
    output logic                        IN_READY,
    output logic [31:0]                 DATA_OUT,
    output logic                        VALID_OUT,
    input  logic                        READY_OUT,
    output logic [2:0]                  NIB_COUNT,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        ERR_DROP
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [6:0][3:0]             acc;
    logic [2:0]                  nib_cnt;
    logic [10:0][3:0]            comb_buf;
    logic [3:0]                  total;
    logic [FIFO_DEPTH-1:0][31:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 level;
    logic                        err_drop;
    logic                        in_ready;
    logic                        beat;
    logic                        do_flush;
    logic                        push;
    logic                        pop;
    logic [31:0]                 push_word;

    // Unused accumulator slots are always zero, so they double as flush padding.
    always_comb begin
        comb_buf      = '0;
        comb_buf[6:0] = acc;
        total         = {1'b0, nib_cnt};
        for (int i = 0; i < 4; i++) begin
            if (MASK_IN[i]) begin
                comb_buf[total] = NIBBLE_IN[i];
                total           = total + 4'd1;
            end
        end
    end

    assign in_ready  = (level < (AW+1)'(FIFO_DEPTH));
    assign beat      = VALID_IN & in_ready;
    assign do_flush  = ~VALID_IN & FLUSH & in_ready & (nib_cnt != 3'd0);
    assign push      = (beat & total[3]) | do_flush;
    assign pop       = (level != '0) & READY_OUT;
    assign push_word = beat ? 32'(comb_buf[7:0]) : {4'h0, acc};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc      <= '0;
            nib_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            err_drop <= 1'b0;
        end else begin
            // total never exceeds 11, so its low bits are the carried-over count
            if (beat) begin
                nib_cnt <= total[2:0];
                acc     <= total[3] ? {16'h0, comb_buf[10:8]} : comb_buf[6:0];
            end else if (do_flush) begin
                acc     <= '0;
                nib_cnt <= '0;
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if ((VALID_IN | FLUSH) & ~in_ready)
                err_drop <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push)
            mem[wr_ptr] <= push_word;
    end

    assign IN_READY   = in_ready;
    assign VALID_OUT  = (level != '0);
    assign DATA_OUT   = VALID_OUT ? mem[rd_ptr] : 32'h0;
    assign NIB_COUNT  = nib_cnt;
    assign FIFO_LEVEL = level;
    assign ERR_DROP   = err_drop;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: a nibble-queue model predicts words and
// status; a negedge monitor checks every word popped from the output FIFO.
module tb_nibble_packer;

    localparam int D = 4;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [3:0][3:0] NIBBLE_IN;
    logic [3:0]      MASK_IN;
    logic            VALID_IN;
    logic            FLUSH;
    logic            IN_READY;
    logic [31:0]     DATA_OUT;
    logic            VALID_OUT;
    logic            READY_OUT;
    logic [2:0]      NIB_COUNT;
    logic [2:0]      FIFO_LEVEL;
    logic            ERR_DROP;

    always #5 CLK = ~CLK;

    nibble_packer #(.FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RESET(RESET), .NIBBLE_IN(NIBBLE_IN), .MASK_IN(MASK_IN),
        .VALID_IN(VALID_IN), .FLUSH(FLUSH), .IN_READY(IN_READY),
        .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .READY_OUT(READY_OUT),
        .NIB_COUNT(NIB_COUNT), .FIFO_LEVEL(FIFO_LEVEL), .ERR_DROP(ERR_DROP)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  nq[$];
    logic [31:0] sb[$];
    int          lvl = 0;
    logic        err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Oldest eight nibbles form a word; missing ones are zero padding.
    function automatic logic [31:0] take_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 8; k++)
            if (nq.size() > 0) w[4*k +: 4] = nq.pop_front();
        return w;
    endfunction

    task automatic sync_check();
        @(posedge CLK);
        #1;
        chk("in_ready",   32'(IN_READY),   32'(lvl < D));
        chk("fifo_level", 32'(FIFO_LEVEL), 32'(lvl));
        chk("valid_out",  32'(VALID_OUT),  32'(lvl != 0));
        chk("nib_count",  32'(NIB_COUNT),  32'(nq.size()));
        chk("err_drop",   32'(ERR_DROP),   32'(err));
    endtask

    task automatic drive(input logic v, input logic [3:0] m, input logic [15:0] n,
                         input logic f, input logic r);
        bit rdy, pu, po;
        rdy = (lvl < D);
        pu  = 1'b0;
        po  = r && (lvl > 0);
        RESET = 1'b0; VALID_IN = v; MASK_IN = m; NIBBLE_IN = n; FLUSH = f; READY_OUT = r;
        if (v) begin
            if (rdy) begin
                for (int i = 0; i < 4; i++)
                    if (m[i]) nq.push_back(n[4*i +: 4]);
                if (nq.size() >= 8) begin
                    sb.push_back(take_word());
                    pu = 1'b1;
                end
            end else err = 1'b1;
        end else if (f) begin
            if (rdy) begin
                if (nq.size() > 0) begin
                    sb.push_back(take_word());
                    pu = 1'b1;
                end
            end else err = 1'b1;
        end
        lvl = lvl + int'(pu) - int'(po);
    endtask

    task automatic step(input logic v, input logic [3:0] m, input logic [15:0] n,
                        input logic f, input logic r);
        sync_check();
        drive(v, m, n, f, r);
    endtask

    task automatic do_reset();
        RESET = 1'b1; VALID_IN = 1'b1; MASK_IN = 4'hF; NIBBLE_IN = 16'($urandom);
        FLUSH = 1'b1; READY_OUT = 1'b1;
        nq.delete(); sb.delete(); lvl = 0; err = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RESET && VALID_OUT === 1'b1 && READY_OUT === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got %h expected no word", DATA_OUT);
            end else begin
                chk("data_out", DATA_OUT, sb.pop_front());
            end
        end
    end

    initial begin
        RESET = 1'b1; VALID_IN = 1'b0; MASK_IN = '0; NIBBLE_IN = '0;
        FLUSH = 1'b0; READY_OUT = 1'b0;
        sync_check();
        chk("reset_data_out", DATA_OUT, 32'h0);
        drive(0, 4'h0, 16'h0, 0, 1);

        // Two full beats make one word
        step(1, 4'hF, 16'h3210, 0, 1);
        step(1, 4'hF, 16'h3210, 0, 1);
        sync_check();
        chk("two_beats_word", DATA_OUT, 32'h32103210);
        chk("two_beats_cnt", 32'(NIB_COUNT), 32'd0);

        // Three partial beats leave one nibble over, then flush it
        drive(1, 4'b0111, 16'h0321, 0, 1);
        step(1, 4'b0111, 16'h0321, 0, 1);
        step(1, 4'b0111, 16'h0321, 0, 1);
        sync_check();
        chk("three_beats_word", DATA_OUT, 32'h21321321);
        chk("three_beats_cnt", 32'(NIB_COUNT), 32'd1);
        drive(0, 4'h0, 16'h0, 1, 1);
        sync_check();
        chk("flush_word", DATA_OUT, 32'h00000003);
        chk("flush_cnt", 32'(NIB_COUNT), 32'd0);

        // Flush with nothing held, then flush alongside a beat
        drive(0, 4'h0, 16'h0, 1, 1);
        sync_check();
        chk("flush_empty_level", 32'(FIFO_LEVEL), 32'd0);
        drive(1, 4'b0011, 16'h00BA, 1, 1);
        sync_check();
        chk("flush_with_beat_cnt", 32'(NIB_COUNT), 32'd2);
        chk("flush_with_beat_level", 32'(FIFO_LEVEL), 32'd0);
        drive(0, 4'h0, 16'h0, 1, 1);
        step(0, 4'h0, 16'h0, 0, 1);
        step(0, 4'h0, 16'h0, 0, 1);

        // Overfill with output stalled
        for (int i = 0; i < 10; i++) step(1, 4'hF, 16'($urandom), 0, 0);
        sync_check();
        chk("full_in_ready", 32'(IN_READY), 32'd0);
        chk("full_level", 32'(FIFO_LEVEL), 32'd4);
        chk("full_err_drop", 32'(ERR_DROP), 32'd1);
        drive(0, 4'h0, 16'h0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 4'h0, 16'h0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 4'hF, 16'($urandom), 0, 1);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 16'h0, 0, 1);

        // Simultaneous push and pop at level 2
        for (int i = 0; i < 5; i++) step(1, 4'hF, 16'($urandom), 0, 0);
        step(1, 4'hF, 16'($urandom), 0, 1);
        sync_check();
        chk("push_pop_level", 32'(FIFO_LEVEL), 32'd2);
        drive(0, 4'h0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 16'h0, 0, 1);

        // Reset with 5 nibbles held and 3 words queued
        for (int i = 0; i < 7; i++) step(1, 4'hF, 16'($urandom), 0, 0);
        step(1, 4'b0001, 16'($urandom), 0, 0);
        sync_check();
        chk("pre_reset_level", 32'(FIFO_LEVEL), 32'd3);
        chk("pre_reset_cnt", 32'(NIB_COUNT), 32'd5);
        do_reset();
        sync_check();
        chk("mid_reset_data_out", DATA_OUT, 32'h0);
        drive(1, 4'hF, 16'hDCBA, 0, 1);
        step(1, 4'hF, 16'hDCBA, 0, 1);
        sync_check();
        chk("post_reset_word", DATA_OUT, 32'hDCBADCBA);
        drive(0, 4'h0, 16'h0, 0, 1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            sync_check();
            if ($urandom_range(0, 199) == 0) do_reset();
            else drive(1'($urandom_range(0, 9) < 7), 4'($urandom), 16'($urandom),
                       1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 6));
        end

        for (int c = 0; c < 40 && (sb.size() != 0 || lvl != 0); c++) step(0, 4'h0, 16'h0, 0, 1);
        sync_check();
        chk("drain_remaining", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
